udma_tgen_tx_lin: RTL

UDMA_TGEN_TX_LIN -- requirements
Module: udma_tgen_tx_lin

---
 rtl/udma_tgen_tx_lin.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/udma_tgen_tx_lin.sv
// Paced traffic generator fed by a uDMA TX linear channel: a credit-limited request front end
// fills a small FIFO, and a pacing FSM emits one word per slot to the downstream port.
module udma_tgen_tx_lin #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cfg_en_i,
    input  logic                  cfg_clr_i,
    input  logic [CNT_WIDTH-1:0]  cfg_period_i,
    input  logic [1:0]            cfg_datasize_i,
    output logic                  data_tx_req_o,
    input  logic                  data_tx_gnt_i,
    output logic [1:0]            data_tx_datasize_o,
    input  logic [DATA_WIDTH-1:0] data_tx_i,
    input  logic                  data_tx_valid_i,
    output logic                  data_tx_ready_o,
    output logic [DATA_WIDTH-1:0] tgen_data_o,
    output logic                  tgen_valid_o,
    input  logic                  tgen_ready_i,
    output logic                  busy_o,
    output logic                  underrun_o
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned OccW = PtrW + 1;
    localparam logic [OccW-1:0] Depth = OccW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StWait, StSend} state_e;

    state_e                state_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q, rd_nxt;
    logic [OccW-1:0]       occ_q, outs_q, drop_q;
    logic [OccW-1:0]       occ_d, outs_d, drop_d;
    logic [OccW:0]         credit;
    logic [DATA_WIDTH-1:0] tdata_q, wdata;
    logic                  underrun_q;
    logic                  grant, beat, push, pop;

    // Buffered words plus in-flight requests may never exceed the FIFO size.
    assign credit = {1'b0, occ_q} + {1'b0, outs_q};
    assign data_tx_req_o = ~rst_i & cfg_en_i & ~cfg_clr_i & (drop_q == '0) &
                           (credit < {1'b0, Depth});
    assign data_tx_ready_o    = (occ_q != Depth);
    assign data_tx_datasize_o = cfg_datasize_i;

    assign grant  = data_tx_req_o & data_tx_gnt_i;
    assign beat   = data_tx_valid_i & data_tx_ready_o;
    assign push   = beat & (drop_q == '0) & ~cfg_clr_i;
    assign pop    = (state_q == StSend) & tgen_ready_i & ~cfg_clr_i;
    assign rd_nxt = rd_ptr_q + PtrW'(1);

    assign tgen_valid_o = (state_q == StSend);
    assign tgen_data_o  = tdata_q;
    assign underrun_o   = underrun_q;
    assign busy_o       = (state_q != StIdle) | (occ_q != '0) | (outs_q != '0) | (drop_q != '0);

    always_comb begin
        wdata = data_tx_i;
        case (cfg_datasize_i)
            2'd0:    wdata = {{(DATA_WIDTH-8){1'b0}}, data_tx_i[7:0]};
            2'd1:    wdata = {{(DATA_WIDTH-16){1'b0}}, data_tx_i[15:0]};
            default: wdata = data_tx_i;
        endcase
    end

    always_comb begin
        occ_d  = occ_q;
        outs_d = outs_q;
        drop_d = drop_q;
        if (cfg_clr_i) begin
            // Every beat still owed to us must be swallowed once it arrives.
            occ_d  = '0;
            outs_d = '0;
            drop_d = drop_q + outs_q + OccW'(grant) - OccW'(beat);
        end else begin
            occ_d  = occ_q + OccW'(push) - OccW'(pop);
            outs_d = outs_q + OccW'(grant) - OccW'(push);
            drop_d = drop_q - OccW'(beat & (drop_q != '0));
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            tdata_q    <= '0;
            underrun_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            outs_q     <= '0;
            drop_q     <= '0;
        end else begin
            occ_q      <= occ_d;
            outs_q     <= outs_d;
            drop_q     <= drop_d;
            underrun_q <= 1'b0;
            if (cfg_clr_i) begin
                state_q  <= StIdle;
                cnt_q    <= '0;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
                if (pop)  rd_ptr_q <= rd_nxt;
                case (state_q)
                    StIdle: begin
                        if (cfg_en_i) begin
                            state_q <= StWait;
                            cnt_q   <= cfg_period_i;
                        end
                    end
                    StWait: begin
                        if (!cfg_en_i) begin
                            state_q <= StIdle;
                        end else if (cnt_q != '0) begin
                            cnt_q <= cnt_q - CNT_WIDTH'(1);
                        end else if (occ_q != '0) begin
                            state_q <= StSend;
                            tdata_q <= mem[rd_ptr_q];
                        end else begin
                            underrun_q <= 1'b1;
                            cnt_q      <= cfg_period_i;
                        end
                    end
                    StSend: begin
                        // Valid holds until the handshake even if the enable drops.
                        if (tgen_ready_i) begin
                            if (!cfg_en_i) begin
                                state_q <= StIdle;
                            end else if (cfg_period_i == '0 && occ_q >= OccW'(2)) begin
                                tdata_q <= mem[rd_nxt];
                            end else begin
                                state_q <= StWait;
                                cnt_q   <= cfg_period_i;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule
